// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : Single-word SPI master supporting all four CPOL/CPHA modes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int SPI_FREQ   = 5_000_000,
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [DATA_WIDTH-1:0] data_send,
    input  logic                  spi_start,
    output logic                  sclk,
    output logic                  csn,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  spi_done,
    output logic [DATA_WIDTH-1:0] data_recv
);

    localparam int HALF   = CLK_FREQ / (2 * SPI_FREQ);
    localparam int CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(HALF - 1);
    localparam logic [EDGE_W-1:0] C_EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);
    localparam logic              C_SCLK_IDLE = (CPOL != 0);
    localparam logic              C_CPHA      = (CPHA != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LEAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_TRAIL = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [EDGE_W-1:0]     r_edge;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;

    logic                  w_tick;
    logic [EDGE_W-1:0]     w_edge_num;
    logic                  w_sample;

    assign w_tick     = (r_cnt == C_CNT_LAST);
    assign w_edge_num = r_edge + 1'b1;
    // Odd edges are leading; CPHA=0 samples on leading, CPHA=1 on trailing.
    assign w_sample   = C_CPHA ? ~w_edge_num[0] : w_edge_num[0];

    always_ff @(posedge clk) begin
        if (arstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            sclk      <= C_SCLK_IDLE;
            csn       <= 1'b1;
            mosi      <= 1'b0;
            spi_done  <= 1'b0;
            data_recv <= '0;
        end else begin
            spi_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The done cycle itself refuses a new start.
                    if (spi_start && !spi_done) begin
                        r_rx    <= '0;
                        r_cnt   <= '0;
                        r_edge  <= '0;
                        csn     <= 1'b0;
                        r_state <= S_LEAD;
                        if (C_CPHA) begin
                            r_tx <= data_send;
                        end else begin
                            mosi <= data_send[DATA_WIDTH-1];
                            r_tx <= {data_send[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                S_LEAD, S_SHIFT: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        sclk   <= ~sclk;
                        r_edge <= w_edge_num;
                        if (w_sample) begin
                            r_rx <= {r_rx[DATA_WIDTH-2:0], miso};
                        end else if (w_edge_num != C_EDGE_LAST) begin
                            mosi <= r_tx[DATA_WIDTH-1];
                            r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end
                        r_state <= (w_edge_num == C_EDGE_LAST) ? S_TRAIL : S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_TRAIL: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        csn       <= 1'b1;
                        spi_done  <= 1'b1;
                        data_recv <= r_rx;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Self-checking bench running all four SPI modes side by side
//            against a transfer-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    localparam int N     = 8;
    localparam int H     = 5;
    localparam int END_T = (2 * N + 1) * H;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         start    = 1'b0;
    logic [N-1:0] dsend    = '0;
    logic [1:0]   miso_sel = 2'd0;

    logic [3:0]   sclk_a, csn_a, mosi_a, miso_a, done_a;
    logic [N-1:0] recv_a [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Mode index m: CPOL = m/2, CPHA = m%2.
    generate
        for (genvar g = 0; g < 4; g++) begin : g_mode
            assign miso_a[g] = (miso_sel == 2'd0) ? mosi_a[g] :
                               (miso_sel == 2'd1) ? 1'b1 :
                               (miso_sel == 2'd2) ? 1'b0 : ~mosi_a[g];
            spi_master #(
                .CLK_FREQ  (50_000_000),
                .SPI_FREQ  (5_000_000),
                .DATA_WIDTH(N),
                .CPOL      (g / 2),
                .CPHA      (g % 2)
            ) u_dut (
                .clk      (clk),
                .arstn    (rst),
                .data_send(dsend),
                .spi_start(start),
                .sclk     (sclk_a[g]),
                .csn      (csn_a[g]),
                .mosi     (mosi_a[g]),
                .miso     (miso_a[g]),
                .spi_done (done_a[g]),
                .data_recv(recv_a[g])
            );
        end
    endgenerate

    function automatic logic [N-1:0] exp_word(input logic [1:0] s, input logic [N-1:0] w);
        case (s)
            2'd0:    return w;
            2'd1:    return '1;
            2'd2:    return '0;
            default: return ~w;
        endcase
    endfunction

    // Reference model: a transfer is a timeline of clk cycles since acceptance.
    bit           m_active = 0;
    bit           m_done   = 0;
    bit           cmp_en   = 0;
    int           m_t      = 0;
    logic [N-1:0] m_word   = '0;
    logic [1:0]   m_sel    = '0;
    logic [N-1:0] m_recv [4];
    logic         m_hold [4];

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0;
            m_done   = 0;
            cmp_en   = 1;
            for (int m = 0; m < 4; m++) begin
                m_recv[m] = '0;
                m_hold[m] = 1'b0;
            end
        end else if (m_active) begin
            m_t++;
            if (m_t == END_T) begin
                m_active = 0;
                m_done   = 1;
                for (int m = 0; m < 4; m++) begin
                    m_recv[m] = exp_word(m_sel, m_word);
                    m_hold[m] = m_word[0];
                end
            end
        end else begin
            if (!m_done && start) begin
                m_active = 1;
                m_t      = 0;
                m_word   = dsend;
                m_sel    = miso_sel;
            end
            m_done = 0;
        end
    end

    task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s mode=%0d t=%0d: got %0h expected %0h at %0t", nm, m, m_t, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int m = 0; m < 4; m++) begin
                int   e, idx, s;
                logic cpol, e_csn, e_sclk, e_mosi, e_done;
                cpol = (m / 2) != 0;
                if (m_active) begin
                    e      = m_t / H;
                    e_csn  = 1'b0;
                    e_done = 1'b0;
                    e_sclk = cpol ^ e[0];
                    if ((m % 2) == 0) begin
                        idx    = (e / 2 > N - 1) ? N - 1 : e / 2;
                        e_mosi = m_word[N-1-idx];
                    end else begin
                        s      = (e + 1) / 2;
                        e_mosi = (s == 0) ? m_hold[m] : m_word[N-s];
                    end
                end else begin
                    e_csn  = 1'b1;
                    e_sclk = cpol;
                    e_done = m_done;
                    e_mosi = m_hold[m];
                end
                chk("csn", m, 32'(csn_a[m]), 32'(e_csn));
                chk("sclk", m, 32'(sclk_a[m]), 32'(e_sclk));
                chk("mosi", m, 32'(mosi_a[m]), 32'(e_mosi));
                chk("spi_done", m, 32'(done_a[m]), 32'(e_done));
                chk("data_recv", m, 32'(recv_a[m]), 32'(m_recv[m]));
            end
        end
    end

    // Waveform measurements on mode 3 (CPOL=1, CPHA=1), used for literal checks.
    int           low_cnt = 0;
    int           rises   = 0;
    logic [N-1:0] bits    = '0;
    logic         p_csn   = 1'b1;
    logic         p_sclk  = 1'b1;

    always @(negedge clk) begin
        if (!csn_a[3] && p_csn) begin
            low_cnt = 0;
            rises   = 0;
            bits    = '0;
        end
        if (!csn_a[3]) low_cnt++;
        if (sclk_a[3] && !p_sclk && !csn_a[3]) begin
            rises++;
            bits = {bits[N-2:0], mosi_a[3]};
        end
        p_csn  = csn_a[3];
        p_sclk = sclk_a[3];
    end

    task automatic lchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output bit ok);
        int n = 0;
        ok = 0;
        while (!ok && n < 400) begin
            @(negedge clk);
            n++;
            if (done_a[0]) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: spi_done not seen within 400 cycles");
        end
    endtask

    task automatic xfer(input logic [N-1:0] w, input logic [1:0] sel, input bit disturb,
                        input bit lit, input logic [N-1:0] exp_r);
        bit ok;
        miso_sel = sel;
        dsend    = w;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin
            cyc(20);
            start = 1'b1;
            dsend = ~w;
            @(negedge clk);
            start = 1'b0;
            cyc(30);
            dsend = N'($urandom);
        end
        wait_done(ok);
        #1;
        if (ok && lit) begin
            for (int m = 0; m < 4; m++) lchk("recv_literal", 32'(recv_a[m]), 32'(exp_r));
            lchk("csn_low_cycles", 32'(low_cnt), 32'd85);
            lchk("sclk_pulses", 32'(rises), 32'd8);
            lchk("mosi_at_rise", 32'(bits), 32'(w));
        end
    endtask

    initial begin
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(2);
        lchk("reset_csn", 32'(csn_a), 32'hF);
        lchk("reset_sclk", 32'(sclk_a), 32'hC);
        lchk("reset_mosi", 32'(mosi_a), 32'h0);
        lchk("reset_done", 32'(done_a), 32'h0);

        xfer(8'hA5, 2'd0, 0, 1, 8'hA5);
        cyc(15);
        xfer(8'h9A, 2'd0, 0, 1, 8'h9A);
        cyc(3);
        xfer(8'h3C, 2'd0, 0, 1, 8'h3C);
        cyc(2);
        xfer(8'h3C, 2'd3, 0, 1, 8'hC3);
        cyc(1);
        xfer(8'h6E, 2'd1, 0, 1, 8'hFF);
        cyc(4);
        xfer(8'h6E, 2'd2, 0, 1, 8'h00);
        cyc(2);
        xfer(8'hA5, 2'd0, 1, 1, 8'hA5);

        // Start held during the done cycle must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(2);
        lchk("start_in_done_ignored", 32'(csn_a), 32'hF);

        // Reset landing on SCLK edge 7 aborts the transfer.
        miso_sel = 2'd0;
        dsend    = 8'h77;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc(34);
        rst = 1'b1;
        @(negedge clk);
        lchk("abort_csn", 32'(csn_a), 32'hF);
        lchk("abort_sclk", 32'(sclk_a), 32'hC);
        lchk("abort_done", 32'(done_a), 32'h0);
        for (int m = 0; m < 4; m++) lchk("abort_recv", 32'(recv_a[m]), 32'h0);
        rst = 1'b0;
        cyc(3);
        xfer(8'h5A, 2'd0, 0, 1, 8'h5A);

        for (int i = 0; i < 12; i++) begin
            logic [N-1:0] w;
            logic [1:0]   s;
            w = N'($urandom);
            s = 2'($urandom_range(0, 3));
            cyc($urandom_range(1, 10));
            xfer(w, s, bit'($urandom_range(0, 1)), 0, '0);
        end
        cyc(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte (parameterisable width) SPI master, all four CPOL/CPHA modes.
- On a one-cycle start request it:
  - asserts chip-select;
  - generates SCLK from the system clock;
  - shifts data_send out MSB-first on mosi while shifting miso into data_recv;
  - releases chip-select and pulses spi_done.
- Sits between a local controller and one external SPI slave.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- SPI_FREQ, 5_000_000, SCLK frequency in Hz. HALF = CLK_FREQ/(2*SPI_FREQ) clk cycles per SCLK half-period; HALF must be >= 1 (default 5).
- DATA_WIDTH, 8, bits per transfer (>= 2).
- CPOL, 0, SCLK idle level (0 = low, 1 = high).
- CPHA, 0, phase:
  - 0: sample on leading edge, shift on trailing edge.
  - 1: shift on leading edge, sample on trailing edge.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- arstn  in  1  reset, synchronous, active-high.
- data_send  in  DATA_WIDTH  word to transmit; captured when spi_start is accepted.
- spi_start  in  1  start request; accepted only in IDLE.
- sclk  out  1  SPI clock, registered.
- csn  out  1  chip select, active-low, registered.
- mosi  out  1  serial data out, MSB first, registered.
- miso  in  1  serial data in.
- spi_done  out  1  one-cycle pulse at end of transfer.
- data_recv  out  DATA_WIDTH  last received word; held until the next transfer completes.

Behaviour:
- Reset (arstn=1 at a clk edge) forces IDLE:
  - csn=1, sclk=CPOL, mosi=0, spi_done=0, data_recv=0;
  - counters and shift registers cleared.
  - Applies immediately, including mid-transfer; the aborted transfer produces no spi_done.
- States: IDLE, LEAD, SHIFT, TRAIL.
- IDLE:
  - Outputs are csn=1, sclk=CPOL, spi_done=0.
  - When spi_start=1 at a clk edge:
    - latch data_send into tx shift register and clear the rx register;
    - set csn=0, go to LEAD.
    - If CPHA=0, mosi = data_send[DATA_WIDTH-1] at that same edge.
- LEAD: sclk stays idle for HALF clk cycles, then the first SCLK edge (toggle) occurs and the state goes to SHIFT.
- SHIFT:
  - 2*DATA_WIDTH SCLK edges, numbered 1..2N; consecutive edges are HALF clk cycles apart.
  - Odd edges are leading, even edges are trailing.
  - Sample edge (even edges if CPHA=1, odd if CPHA=0): miso is registered into the rx shift register LSB, shifting left, at the same clk edge that toggles sclk.
  - Shift edge (odd if CPHA=1, even if CPHA=0): mosi takes the next tx bit.
    - CPHA=1: edge 1 drives the MSB.
    - CPHA=0: the last shift edge (2N) does not change mosi.
  - After edge 2N, go to TRAIL.
- TRAIL:
  - sclk rests at CPOL for HALF clk cycles.
  - At the final edge: csn=1, spi_done=1 for exactly one cycle, data_recv loads the rx register, state returns to IDLE.
- Timing:
  - csn low for exactly HALF*(2N+1) clk cycles (85 at defaults).
  - sclk period is 2*HALF cycles with 50% duty.
  - Exactly N full SCLK pulses per transfer.
- spi_start while not IDLE is ignored, including during the spi_done cycle.
- data_send changes after acceptance do not affect the transfer in progress.
- mosi holds its last value between transfers until reset or the next start.
- A new transfer may begin on the cycle after spi_done.

Test Plan:
- CPOL=1, CPHA=1, miso looped to mosi; reset then start with 0xA5 -> csn low 85 cycles, 8 SCLK pulses (idle high), mosi bits 1,0,1,0,0,1,0,1 stable at each rising (sample) edge, spi_done one-cycle pulse with csn rise, data_recv=0xA5.
- Back-to-back: 15 cycles after spi_done falls, start with 0x9A -> data_recv=0x9A, second transfer independent of the first.
- Mode sweep CPOL/CPHA in {0,1}^2 with a loopback and a slave model sampling on the correct edge -> 0x3C received both ways; sclk idle level equals CPOL before and after.
- miso tied 1 then tied 0 -> data_recv=0xFF then 0x00.
- spi_start pulsed again mid-transfer, and data_send changed mid-transfer -> ignored; still exactly 8 pulses, original word sent, single spi_done.
- Reset asserted at SCLK edge 7 -> next cycle csn=1, sclk=CPOL, data_recv=0, spi_done never pulses; subsequent start with 0x5A completes normally.
